// File: rtl/bnn_logit_accumulator.sv
// BNN output stage: accumulates XNOR popcounts per class, converts them
// to signed logits, scans for the argmax and holds the result until consumed.
module bnn_logit_accumulator #(
    parameter int WIDTH    = 32,
    parameter int BEATS    = 4,
    parameter int CHANNELS = 10,
    localparam int N  = WIDTH * BEATS,
    localparam int CW = $clog2(N + 1),
    localparam int LW = CW + 1,
    localparam int IW = $clog2(CHANNELS)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [CHANNELS*WIDTH-1:0] xnor_in,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [CHANNELS*LW-1:0]   logits,
    output logic [IW-1:0]            class_idx
);

    localparam int BW = (BEATS > 1) ? $clog2(BEATS) : 1;

    typedef enum logic [1:0] {
        ACC,
        SCAN,
        OUT
    } state_t;

    state_t              state;
    state_t              state_nxt;
    logic [BW-1:0]       beat;
    logic [CW-1:0]       acc [CHANNELS];
    logic [IW-1:0]       idx;
    logic signed [LW-1:0] logit_q [CHANNELS];
    logic signed [LW-1:0] best;
    logic [IW-1:0]       best_idx;

    logic                accept;
    logic                handshake;
    logic                last_beat;
    logic                last_idx;
    logic                take;
    logic [LW-1:0]       dbl;
    logic signed [LW-1:0] logit_cur;

    function automatic logic [CW-1:0] popcount(input logic [WIDTH-1:0] v);
        logic [CW-1:0] s;
        s = '0;
        for (int i = 0; i < WIDTH; i++) begin
            s = s + CW'(v[i]);
        end
        return s;
    endfunction

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state)
            ACC: begin
                in_ready = 1'b1;
                if (in_valid && last_beat) begin
                    state_nxt = SCAN;
                end
            end
            SCAN: begin
                if (last_idx) begin
                    state_nxt = OUT;
                end
            end
            OUT: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_nxt = ACC;
                end
            end
            default: state_nxt = ACC;
        endcase
    end

    assign accept    = in_valid && (state == ACC);
    assign handshake = out_ready && (state == OUT);
    assign last_beat = (beat == BW'(BEATS - 1));
    assign last_idx  = (idx == IW'(CHANNELS - 1));

    // 2*count fits LW bits unsigned; the wrap-around subtraction lands in [-N, N].
    assign dbl       = {acc[idx], 1'b0};
    assign logit_cur = $signed(dbl - LW'(N));
    assign take      = (idx == '0) || (logit_cur > best);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ACC;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            beat <= '0;
            for (int c = 0; c < CHANNELS; c++) begin
                acc[c] <= '0;
            end
        end else if (accept) begin
            beat <= last_beat ? '0 : beat + BW'(1);
            for (int c = 0; c < CHANNELS; c++) begin
                acc[c] <= acc[c] + popcount(xnor_in[c*WIDTH +: WIDTH]);
            end
        end else if (handshake) begin
            for (int c = 0; c < CHANNELS; c++) begin
                acc[c] <= '0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx      <= '0;
            best     <= '0;
            best_idx <= '0;
            for (int c = 0; c < CHANNELS; c++) begin
                logit_q[c] <= '0;
            end
        end else if (state == SCAN) begin
            idx          <= last_idx ? '0 : idx + IW'(1);
            logit_q[idx] <= logit_cur;
            if (take) begin
                best     <= logit_cur;
                best_idx <= idx;
            end
        end
    end

    always_comb begin
        logits = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            logits[c*LW +: LW] = logit_q[c];
        end
    end

    assign class_idx = best_idx;

endmodule

// File: tb/tb_bnn_logit_accumulator.sv
// Scoreboard bench for bnn_logit_accumulator: two configurations,
// directed vectors with hand-computed logits and argmax.
module tb_bnn_logit_accumulator;

    localparam int WA = 8, BA = 4, CA = 4, LWA = 7, IWA = 2;
    localparam int WB = 5, BB = 1, CB = 3, LWB = 4, IWB = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic                 a_in_valid, a_in_ready, a_out_valid, a_out_ready;
    logic [CA*WA-1:0]     a_xnor;
    logic [CA*LWA-1:0]    a_logits;
    logic [IWA-1:0]       a_class;

    logic                 b_in_valid, b_in_ready, b_out_valid, b_out_ready;
    logic [CB*WB-1:0]     b_xnor;
    logic [CB*LWB-1:0]    b_logits;
    logic [IWB-1:0]       b_class;

    bnn_logit_accumulator #(.WIDTH(WA), .BEATS(BA), .CHANNELS(CA)) dut_a (
        .clk(clk), .rst(rst),
        .in_valid(a_in_valid), .in_ready(a_in_ready), .xnor_in(a_xnor),
        .out_valid(a_out_valid), .out_ready(a_out_ready),
        .logits(a_logits), .class_idx(a_class)
    );

    bnn_logit_accumulator #(.WIDTH(WB), .BEATS(BB), .CHANNELS(CB)) dut_b (
        .clk(clk), .rst(rst),
        .in_valid(b_in_valid), .in_ready(b_in_ready), .xnor_in(b_xnor),
        .out_valid(b_out_valid), .out_ready(b_out_ready),
        .logits(b_logits), .class_idx(b_class)
    );

    int total  = 0;
    int passed = 0;
    int qa[$];
    int qb[$];

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    endtask

    task automatic push_a(input int l0, input int l1, input int l2,
                          input int l3, input int c);
        qa.push_back(l0); qa.push_back(l1); qa.push_back(l2);
        qa.push_back(l3); qa.push_back(c);
    endtask

    task automatic push_b(input int l0, input int l1, input int l2,
                          input int c);
        qb.push_back(l0); qb.push_back(l1); qb.push_back(l2);
        qb.push_back(c);
    endtask

    always @(negedge clk) begin
        if (!rst && a_out_valid && a_out_ready) begin
            if (qa.size() < CA + 1) begin
                chk("a_unexpected_output", 1, 0);
            end else begin
                for (int c = 0; c < CA; c++) begin
                    logic signed [LWA-1:0] v;
                    v = a_logits[c*LWA +: LWA];
                    chk($sformatf("a_logit%0d", c), int'(v), qa.pop_front());
                end
                chk("a_class", int'(a_class), qa.pop_front());
            end
        end
    end

    always @(negedge clk) begin
        if (!rst && b_out_valid && b_out_ready) begin
            if (qb.size() < CB + 1) begin
                chk("b_unexpected_output", 1, 0);
            end else begin
                for (int c = 0; c < CB; c++) begin
                    logic signed [LWB-1:0] v;
                    v = b_logits[c*LWB +: LWB];
                    chk($sformatf("b_logit%0d", c), int'(v), qb.pop_front());
                end
                chk("b_class", int'(b_class), qb.pop_front());
            end
        end
    end

    task automatic beat_a(input logic [CA*WA-1:0] d);
        bit done;
        done = 1'b0;
        a_in_valid = 1'b1;
        a_xnor = d;
        for (int t = 0; t < 100 && !done; t++) begin
            @(negedge clk);
            if (a_in_ready) begin
                @(posedge clk);
                #1;
                done = 1'b1;
            end
        end
        a_in_valid = 1'b0;
        a_xnor = '0;
        if (!done) chk("a_beat_timeout", 0, 1);
    endtask

    task automatic beat_b(input logic [CB*WB-1:0] d);
        bit done;
        done = 1'b0;
        b_in_valid = 1'b1;
        b_xnor = d;
        for (int t = 0; t < 100 && !done; t++) begin
            @(negedge clk);
            if (b_in_ready) begin
                @(posedge clk);
                #1;
                done = 1'b1;
            end
        end
        b_in_valid = 1'b0;
        b_xnor = '0;
        if (!done) chk("b_beat_timeout", 0, 1);
    endtask

    task automatic vec_a(input logic [CA*WA-1:0] d);
        for (int i = 0; i < BA; i++) beat_a(d);
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_valid_a(output int cyc);
        cyc = 0;
        while (!a_out_valid && cyc < 100) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        if (!a_out_valid) chk("a_valid_timeout", 0, 1);
    endtask

    task automatic drain;
        for (int t = 0; t < 300 && (qa.size() != 0 || qb.size() != 0); t++) begin
            @(posedge clk);
        end
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        int cyc;
        int seen;
        logic [CA*LWA-1:0] cap_l;
        logic [IWA-1:0]    cap_c;

        a_in_valid = 0; a_xnor = '0; a_out_ready = 1;
        b_in_valid = 0; b_xnor = '0; b_out_ready = 1;
        #12;
        chk("rst_a_in_ready", int'(a_in_ready), 1);
        chk("rst_a_out_valid", int'(a_out_valid), 0);
        chk("rst_a_logits_zero", int'(a_logits == '0), 1);
        chk("rst_a_class", int'(a_class), 0);
        chk("rst_b_in_ready", int'(b_in_ready), 1);
        chk("rst_b_out_valid", int'(b_out_valid), 0);
        @(posedge clk);
        #1;
        rst = 0;
        idle(1);

        // all ones: tie at +32, lowest index wins; latency check
        push_a(32, 32, 32, 32, 0);
        vec_a('1);
        wait_valid_a(cyc);
        chk("t1_latency", cyc, 4);

        push_a(-32, -32, 32, -32, 2);
        vec_a(32'h00FF0000);
        push_a(-32, -32, 32, 0, 2);
        vec_a(32'h0FFF0000);

        // gaps between beats, in_valid held through SCAN/OUT
        drain();
        push_a(-32, -32, 32, -32, 2);
        beat_a(32'h00FF0000);
        idle(2);
        beat_a(32'h00FF0000);
        idle(1);
        beat_a(32'h00FF0000);
        idle(3);
        a_out_ready = 0;
        beat_a(32'h00FF0000);
        a_in_valid = 1;
        a_xnor = '1;
        wait_valid_a(cyc);
        idle(3);
        a_in_valid = 0;
        a_xnor = '0;
        a_out_ready = 1;

        // hold in OUT for 10 cycles
        drain();
        push_a(-24, -16, -32, -32, 1);
        a_out_ready = 0;
        beat_a(32'h0000FF01);
        beat_a(32'h00000001);
        beat_a(32'h00000001);
        beat_a(32'h00000001);
        wait_valid_a(cyc);
        cap_l = a_logits;
        cap_c = a_class;
        for (int i = 0; i < 10; i++) begin
            idle(1);
            chk("t4_hold_stable", int'(a_out_valid && !a_in_ready &&
                a_logits == cap_l && a_class == cap_c), 1);
        end
        a_out_ready = 1;
        push_a(-32, -32, -32, -32, 0);
        vec_a(32'h00000000);
        push_a(-32, 32, -32, 32, 1);
        vec_a(32'hFF00FF00);

        // reset mid-vector
        drain();
        beat_a('1);
        beat_a('1);
        rst = 1;
        idle(1);
        rst = 0;
        push_a(-32, -32, -32, 32, 3);
        vec_a(32'hFF000000);

        // reset during SCAN
        drain();
        vec_a('1);
        idle(2);
        rst = 1;
        #2;
        chk("scan_rst_out_valid", int'(a_out_valid), 0);
        chk("scan_rst_in_ready", int'(a_in_ready), 1);
        chk("scan_rst_logits", int'(a_logits == '0), 1);
        chk("scan_rst_class", int'(a_class), 0);
        idle(1);
        rst = 0;
        seen = 0;
        for (int i = 0; i < 8; i++) begin
            idle(1);
            if (a_out_valid) seen++;
        end
        chk("scan_rst_no_valid", seen, 0);
        push_a(32, -32, -32, -32, 0);
        vec_a(32'h000000FF);

        // BEATS=1 config, back-to-back with out_ready high
        push_b(5, -5, 1, 0);
        push_b(-3, 3, 3, 1);
        push_b(-5, -5, 5, 2);
        beat_b({5'b11100, 5'b00000, 5'b11111});
        beat_b({5'b11110, 5'b11110, 5'b00001});
        beat_b({5'b11111, 5'b00000, 5'b00000});

        drain();
        idle(2);
        chk("a_queue_empty", qa.size(), 0);
        chk("b_queue_empty", qb.size(), 0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/bnn_logit_accumulator.md
Name: bnn_logit_accumulator

Overview:
- Output stage of the binarised classifier.
- Accumulates popcounts of XNOR result vectors for CHANNELS output neurons, streamed as BEATS chunks of WIDTH bits each.
- Converts each accumulated count to a signed logit, 2*count - WIDTH*BEATS.
- Selects the argmax class with a sequential scan, then presents all logits plus the winning index on a valid/ready output.

Parameters:
- WIDTH, 32, XNOR bits per channel per beat.
- BEATS, 4, beats per inference vector; total bits per channel N = WIDTH*BEATS; BEATS >= 1.
- CHANNELS, 10, output neurons/classes; CHANNELS >= 2.
- Derived: CW = $clog2(N+1) (count width); LW = CW+1 (signed logit width); IW = $clog2(CHANNELS).

Ports:
- clk  input  1  Rising-edge clock.
- rst  input  1  Asynchronous, active-high reset.
- in_valid  input  1  xnor_in beat valid.
- in_ready  output  1  Block accepts a beat.
- xnor_in  input  CHANNELS*WIDTH  Channel c occupies bits [c*WIDTH +: WIDTH].
- out_valid  output  1  Logits and class valid.
- out_ready  input  1  Downstream consumes the result.
- logits  output  CHANNELS*LW  Signed two's-complement; channel c at [c*LW +: LW].
- class_idx  output  IW  Argmax channel.

Behaviour:
- Reset, asynchronous: state=ACC, beat counter=0, all accumulators=0, scan index=0, best=0, in_ready=1, out_valid=0, logits=0, class_idx=0.
- State ACC, in_ready=1:
  - On in_valid&in_ready, each channel accumulator += popcount of its WIDTH slice; beat counter increments.
  - Accumulators are CW bits and cannot overflow (max N).
  - When the accepted beat is beat BEATS-1, the counter wraps to 0 and the next state is SCAN with scan index 0.
- State SCAN, in_ready=0, out_valid=0:
  - One channel per cycle: logit[i] = (acc[i]<<1) - N, computed at LW bits signed.
  - Index 0 loads best value and best index unconditionally.
  - Index i>0 replaces best only if logit[i] is strictly greater (signed compare), so ties resolve to the lowest index.
  - After processing index CHANNELS-1, next state is OUT.
- State OUT: out_valid=1, in_ready=0.
  - logits and class_idx are registered and held stable until out_valid&out_ready.
  - On that handshake: out_valid=0, accumulators cleared, state returns to ACC.
  - The next vector's first beat can be accepted in the cycle after the handshake.
- Latency: out_valid rises on the CHANNELS-th rising edge after the edge that accepted the final beat.
- Range: logit is in [-N, N]. logits is an output register loaded as each channel is scanned, or an equivalent combinational view of frozen accumulators. Both must read correctly while out_valid=1.
- in_valid while in_ready=0 is ignored: no accumulation, no stall side effects.
- out_ready while out_valid=0 is ignored.
- BEATS=1: every accepted beat goes straight to SCAN.
- Reset mid-vector, mid-scan or while holding output aborts all work; the first post-reset beat is treated as beat 0.
- xnor_in content is don't-care when not handshaking; X on it must not corrupt state.

Test Plan:
1. WIDTH=8, BEATS=4, CHANNELS=4; all-ones on every channel for 4 beats -> logits all +32, class_idx=0 (tie, lowest index), out_valid 4 edges after the last beat.
2. Channel 2 all-ones, others all-zero for 4 beats -> logits {-32,-32,+32,-32}, class_idx=2. Repeat with channel 3 at 0x0F every beat (count 16) -> logit 0 for channel 3.
3. in_valid toggled with gaps, and held high through SCAN/OUT -> only 4 beats are accumulated; beats offered while in_ready=0 are not counted; results identical to the gapless run.
4. Hold out_ready=0 for 10 cycles in OUT -> logits and class_idx stable, in_ready=0. Release -> one handshake, accumulators cleared, next vector's results independent of the previous one.
5. Assert rst after 2 of 4 beats, then send a fresh 4-beat vector -> results reflect only the fresh vector. Assert rst during SCAN -> out_valid stays 0, all outputs reset.
6. BEATS=1, CHANNELS=3, WIDTH=5; slices 0b11111/0b00000/0b11100 -> logits {+5,-5,+1}, class_idx=0, back-to-back vectors with out_ready tied high.
